// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Each grant runs a valid/accept handshake, waits for tx_done, then acks the requester.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transfer in flight; sample req and pick the next grant
// S_ISSUE   | tx_valid high; waiting for the transmitter to take the byte
// S_WAIT_DONE | byte accepted; waiting for the tx_done pulse
// S_ACK     | one-cycle ack (ack_err set if the watchdog fired)
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      ack_err,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_accept,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ACK       = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [GW-1:0]       r_last;
    logic [GW-1:0]       r_grant;
    logic [TW-1:0]       r_timer;
    logic [N_REQ-1:0]    r_ack;
    logic                r_ack_err;
    logic                r_tx_valid;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_busy;

    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic                w_expired;
    logic                w_abort;

    // Scan last+1, last+2, ... so the most recently served requester ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && req[GW'((int'(r_last) + i) % N_REQ)]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_last) + i) % N_REQ);
            end
        end
    end

    // ">=" rather than "==": an accept on the very last cycle moves the timer past
    // TIMEOUT-1, and the watchdog must still be able to fire in WAIT_DONE.
    assign w_expired = (r_timer >= TO_LAST);

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (tx_accept) begin
                    w_next = S_WAIT_DONE;
                end else if (w_expired) begin
                    w_next  = S_ACK;
                    w_abort = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    w_next = S_ACK;
                end else if (w_expired) begin
                    w_next  = S_ACK;
                    w_abort = 1'b1;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= GW'(N_REQ - 1);
            r_grant    <= '0;
            r_timer    <= '0;
            r_ack      <= '0;
            r_ack_err  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);
            r_tx_valid <= (w_next == S_ISSUE);
            r_ack_err  <= w_abort;
            r_ack      <= (w_next == S_ACK) ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_grant) : '0;

            if (r_state == S_IDLE && w_found) begin
                r_grant   <= w_pick;
                r_tx_data <= req_data[int'(w_pick)*DATA_W +: DATA_W];
                r_timer   <= '0;
            end else if ((r_state == S_ISSUE || r_state == S_WAIT_DONE) && r_timer != TO_MAX) begin
                r_timer <= r_timer + 1'b1;
            end

            if (r_state == S_ACK) begin
                r_last <= r_grant;
            end
        end
    end

    assign ack      = r_ack;
    assign ack_err  = r_ack_err;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a main instance with an automatic transmitter model and
// scoreboard, plus a short-watchdog instance for the timeout corner cases.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  bytes [4];
    logic [31:0] req_data;
    assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    // main instance
    logic [3:0]  req = '0;
    logic [3:0]  ack;
    logic        ack_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_accept;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;

    // watchdog instance
    logic [3:0]  wd_req = '0;
    logic [3:0]  wd_ack;
    logic        wd_ack_err;
    logic        wd_tx_valid;
    logic [7:0]  wd_tx_data;
    logic        wd_accept = 1'b0;
    logic        wd_done = 1'b0;
    logic        wd_busy;
    logic [1:0]  wd_grant_id;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .ack_err(ack_err), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_accept(tx_accept), .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) u_wd (
        .clk(clk), .rst(rst), .req(wd_req), .req_data(req_data),
        .ack(wd_ack), .ack_err(wd_ack_err), .tx_valid(wd_tx_valid), .tx_data(wd_tx_data),
        .tx_accept(wd_accept), .tx_done(wd_done), .busy(wd_busy), .grant_id(wd_grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] id;
        logic       err;
        logic [7:0] data;
    } exp_t;
    exp_t sb [$];

    task automatic push_exp(input logic [1:0] id);
        exp_t e;
        e.id   = id;
        e.err  = 1'b0;
        e.data = bytes[id];
        sb.push_back(e);
    endtask

    // transmitter model: accept acc_dly cycles after ISSUE entry, done done_dly cycles after accept
    int acc_dly  = 1;
    int done_dly = 3;
    int rs = 0;
    int cnt = 0;
    always @(negedge clk) begin
        tx_accept = 1'b0;
        tx_done   = 1'b0;
        if (rst) begin
            rs = 0;
        end else begin
            case (rs)
                0: if (tx_valid) begin
                    if (acc_dly == 0) begin
                        tx_accept = 1'b1;
                        rs = 2;
                        cnt = done_dly;
                    end else begin
                        rs = 1;
                        cnt = acc_dly;
                    end
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        tx_accept = 1'b1;
                        rs = 2;
                        cnt = done_dly;
                    end
                end
                default: begin
                    if (cnt <= 1) begin
                        tx_done = 1'b1;
                        rs = 0;
                    end else begin
                        cnt--;
                    end
                end
            endcase
        end
    end

    // scoreboard monitor on the main instance
    logic       valid_prev = 1'b0;
    logic [7:0] seen_data = '0;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (tx_valid && !valid_prev) seen_data = tx_data;
            valid_prev = tx_valid;
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack=%b, expected no ack", ack);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_vec",  32'(ack),       32'(4'b0001 << mon_e.id));
                    chk("ack_err",  32'(ack_err),   32'(mon_e.err));
                    chk("grant_id", 32'(grant_id),  32'(mon_e.id));
                    chk("tx_data",  32'(seen_data), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic wait_ack(output logic [3:0] v);
        logic got;
        got = 1'b0;
        v = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                v = ack;
                got = 1'b1;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_wait: no ack within 300 cycles, expected one");
        end
    endtask

    typedef struct {
        logic [3:0] req;
        int         acc;
        int         dly;
        logic [1:0] id;
    } vec_t;
    vec_t vt [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v;
        logic       hit;

        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'hA5;
        bytes[3] = 8'h44;

        vt[0] = '{req: 4'b0100, acc: 3, dly: 20, id: 2'd2};
        vt[1] = '{req: 4'b1111, acc: 1, dly: 3,  id: 2'd3};
        vt[2] = '{req: 4'b0011, acc: 0, dly: 1,  id: 2'd0};
        vt[3] = '{req: 4'b0011, acc: 2, dly: 5,  id: 2'd1};
        vt[4] = '{req: 4'b1001, acc: 1, dly: 2,  id: 2'd3};
        vt[5] = '{req: 4'b1001, acc: 4, dly: 1,  id: 2'd0};
        vt[6] = '{req: 4'b0001, acc: 1, dly: 1,  id: 2'd0};
        vt[7] = '{req: 4'b0110, acc: 2, dly: 7,  id: 2'd1};

        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_ack",      32'(ack),      32'd0);
        chk("rst_ack_err",  32'(ack_err),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // all four request, each drops after its ack: order 0,1,2,3
        acc_dly = 1;
        done_dly = 3;
        for (int i = 0; i < 4; i++) push_exp(2'(i));
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(v);
            req = req & ~v;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // 1 and 3 held continuously: strict alternation
        for (int i = 0; i < 8; i++) push_exp((i % 2 == 0) ? 2'd1 : 2'd3);
        req = 4'b1010;
        for (int i = 0; i < 8; i++) wait_ack(v);
        req = '0;
        repeat (2) @(negedge clk);

        // table of single transfers; round-robin pointer carries across entries
        for (int i = 0; i < 8; i++) begin
            acc_dly  = vt[i].acc;
            done_dly = vt[i].dly;
            push_exp(vt[i].id);
            req = vt[i].req;
            wait_ack(v);
            req = '0;
            @(negedge clk);
        end

        // reset in WAIT_DONE: outputs clear at once, pointer returns to favour requester 0
        acc_dly = 1;
        done_dly = 30;
        req = 4'b0100;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (busy && !tx_valid) hit = 1'b1;
        end
        chk("reach_wait_done", 32'(hit), 32'd1);
        req = '0;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd0);
        chk("arst_tx_data",  32'(tx_data),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_dly = 3;
        req = 4'b1001;
        push_exp(2'd0);
        wait_ack(v);
        req = '0;
        repeat (2) @(negedge clk);

        // watchdog: no accept, abort exactly 16 cycles after ISSUE entry
        wd_req = 4'b0001;
        @(negedge clk);
        chk("wd_latency",  32'(wd_tx_valid), 32'd1);
        chk("wd_grant0",   32'(wd_grant_id), 32'd0);
        chk("wd_data0",    32'(wd_tx_data),  32'h11);
        wd_req = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                chk("wd_valid_15", 32'(wd_tx_valid), 32'd1);
                chk("wd_ack_15",   32'(wd_ack),      32'd0);
            end
        end
        chk("wd_abort_ack",   32'(wd_ack),      32'b0001);
        chk("wd_abort_err",   32'(wd_ack_err),  32'd1);
        chk("wd_abort_valid", 32'(wd_tx_valid), 32'd0);
        wd_req = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        chk("wd_next_valid", 32'(wd_tx_valid), 32'd1);
        chk("wd_next_grant", 32'(wd_grant_id), 32'd1);
        chk("wd_next_data",  32'(wd_tx_data),  32'h22);

        // tx_done on the last timer cycle wins over the watchdog
        wd_accept = 1'b1;
        wd_req = '0;
        @(negedge clk);
        wd_accept = 1'b0;
        repeat (14) @(negedge clk);
        wd_done = 1'b1;
        @(negedge clk);
        wd_done = 1'b0;
        chk("wd_edge_ack", 32'(wd_ack),     32'b0010);
        chk("wd_edge_err", 32'(wd_ack_err), 32'd0);
        @(negedge clk);
        chk("wd_idle_busy", 32'(wd_busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
